// File: rtl/inst_queue_pkg.sv
// Shared constants and helper types for the instruction queue between decode
// and the scoreboard.
package inst_queue_pkg;

  // Payload width of one decoded instruction word on id_to_sb_bus.
  localparam int ID_TO_SB_WD = 137;
  // Default queue depth for the system build.
  localparam int IQ_DEPTH    = 8;
  // Location of the program counter inside the decoded word.
  localparam int PC_LSB      = 0;
  localparam int PC_W        = 32;

  // Per-cycle queue operations after all qualification has been applied.
  typedef struct packed {
    logic flush;
    logic push;
    logic pop;
  } iq_op_t;

  // Extracts the program counter field from a decoded word.
  function automatic logic [PC_W-1:0] bus_pc(input logic [ID_TO_SB_WD-1:0] bus);
    return bus[PC_LSB +: PC_W];
  endfunction

endpackage

// File: rtl/inst_queue_fifo_ram.sv
// Storage array for the instruction queue: one synchronous write port and
// one asynchronous read port. Contents are not reset; the control logic
// never presents an entry that was not written since the last flush.
module fifo_ram #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 137,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [PTR_W-1:0] raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write the pushed word into the slot at the write pointer.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Head entry is read combinationally so it is visible in the cycle after the write.
  assign rdata = mem[raddr];

endmodule

// File: rtl/inst_queue.sv
// Decoupling FIFO between decode and the scoreboard. Holds decoded words in
// program order, raises the decoder stall one entry early so the word already
// in flight still fits, and discards everything on a branch redirect.
module inst_queue
  import inst_queue_pkg::*;
#(
  parameter int DEPTH = IQ_DEPTH,
  parameter int WIDTH = ID_TO_SB_WD,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             br_e,
  input  logic             inst_valid,
  input  logic [WIDTH-1:0] id_to_sb_bus,
  output logic             stall,
  output logic             sb_valid,
  output logic [WIDTH-1:0] sb_bus,
  input  logic             sb_ready,
  output logic [PTR_W:0]   count
);

  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             stall_q;
  logic [WIDTH-1:0] head;
  iq_op_t           op;

  // Stall depends only on the registered occupancy, never on this cycle's inputs.
  assign stall    = (count >= (PTR_W+1)'(DEPTH-1));
  assign sb_valid = (count != '0);
  assign sb_bus   = sb_valid ? head : '0;

  // Qualify push and pop; stall_q suppresses words the decoder is merely holding.
  always_comb begin
    op       = '0;
    op.flush = br_e;
    op.push  = inst_valid & ~stall_q & ~br_e;
    op.pop   = sb_valid & sb_ready & ~br_e;
  end

  // Pointer, occupancy and stall history update; redirect wins over everything.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      stall_q <= 1'b0;
    end else if (op.flush) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      stall_q <= 1'b0;
    end else begin
      stall_q <= stall;
      if (op.push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (op.pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({op.push, op.pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  fifo_ram #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH),
    .PTR_W (PTR_W)
  ) u_ram (
    .clk   (clk),
    .we    (op.push),
    .waddr (wr_ptr),
    .wdata (id_to_sb_bus),
    .raddr (rd_ptr),
    .rdata (head)
  );

  // The early stall guarantees a push never lands on a full queue.
  assert property (@(posedge clk) disable iff (!resetn)
                   !(op.push && (count == (PTR_W+1)'(DEPTH))));

endmodule

// File: tb/tb_inst_queue.sv
// Self-checking bench for inst_queue. The driver behaves like the decoder
// (loads a new word only after an edge where stall was low, holds otherwise,
// presents a bubble after a redirect). A negedge monitor keeps an ordered
// model of the queue contents and checks occupancy, stall and the head word.
module tb_inst_queue;
  import inst_queue_pkg::*;

  localparam int DEPTH = 8;
  localparam int WIDTH = ID_TO_SB_WD;
  localparam int PTR_W = $clog2(DEPTH);

  logic             clk = 1'b0;
  logic             resetn;
  logic             br_e;
  logic             inst_valid;
  logic [WIDTH-1:0] id_to_sb_bus;
  logic             stall;
  logic             sb_valid;
  logic [WIDTH-1:0] sb_bus;
  logic             sb_ready;
  logic [PTR_W:0]   count;

  int checks   = 0;
  int failures = 0;

  logic [WIDTH-1:0] exp_q[$];
  logic             fresh  = 1'b0;
  logic             mon_en = 1'b0;

  inst_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH), .PTR_W(PTR_W)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .br_e         (br_e),
    .inst_valid   (inst_valid),
    .id_to_sb_bus (id_to_sb_bus),
    .stall        (stall),
    .sb_valid     (sb_valid),
    .sb_bus       (sb_bus),
    .sb_ready     (sb_ready),
    .count        (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] mk_word(input logic [31:0] pc);
    logic [159:0] r;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return {r[WIDTH-PC_W-1:0], pc};
  endfunction

  // One decoder cycle: the stall seen during the previous cycle decides
  // whether a new word is loaded at this edge.
  task automatic step(input logic want_valid, input logic [31:0] pc,
                      input logic rdy, input logic br);
    logic ls, lb;
    ls = stall;
    lb = br_e;
    @(posedge clk);
    #1;
    if (lb) begin
      inst_valid   = 1'b0;
      id_to_sb_bus = '0;
      fresh        = 1'b0;
    end else if (!ls) begin
      inst_valid   = want_valid;
      id_to_sb_bus = mk_word(pc);
      fresh        = want_valid;
    end else begin
      fresh = 1'b0;
    end
    sb_ready = rdy;
    br_e     = br;
  endtask

  // Monitor: compare DUT against the model, then apply this cycle's events.
  always @(negedge clk) begin
    int sz;
    if (mon_en && resetn) begin
      sz = exp_q.size();
      check("count", WIDTH'(count), WIDTH'(sz));
      check("stall", WIDTH'(stall), WIDTH'(sz >= DEPTH - 1));
      check("sb_valid", WIDTH'(sb_valid), WIDTH'(sz != 0));
      if (sz != 0) check("head", sb_bus, exp_q[0]);
      else         check("bus_empty", sb_bus, '0);
      if (br_e) begin
        exp_q.delete();
      end else begin
        if (sz != 0 && sb_ready) void'(exp_q.pop_front());
        if (fresh) exp_q.push_back(id_to_sb_bus);
        if (exp_q.size() > DEPTH) begin
          failures++;
          $display("FAIL model_overflow actual=%0d required<=%0d", exp_q.size(), DEPTH);
        end
      end
    end
  end

  initial begin
    int n;
    resetn       = 1'b0;
    br_e         = 1'b0;
    inst_valid   = 1'b0;
    id_to_sb_bus = '0;
    sb_ready     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_count", WIDTH'(count), '0);
    check("rst_valid", WIDTH'(sb_valid), '0);
    check("rst_stall", WIDTH'(stall), '0);
    check("rst_bus", sb_bus, '0);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    mon_en = 1'b1;

    // Single pass
    step(1'b1, 32'hBFC0_0000, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    check("single_valid", WIDTH'(sb_valid), WIDTH'(1));
    check("single_pc", WIDTH'(bus_pc(sb_bus)), WIDTH'(32'hBFC0_0000));
    step(1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    check("single_drained", WIDTH'(count), '0);

    // Fill, then hold inst_valid while stalled
    for (int i = 0; i < 14; i++) step(1'b1, 32'h1000 + 32'(i * 4), 1'b0, 1'b0);
    check("fill_count", WIDTH'(count), WIDTH'(DEPTH));
    check("fill_stall", WIDTH'(stall), WIDTH'(1));

    // Release with skid, then drain
    for (int i = 0; i < 2; i++) step(1'b1, 32'h2000 + 32'(i * 4), 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b1, 32'h2100 + 32'(i * 4), 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) step(1'b0, 32'h0, 1'b1, 1'b0);

    // Flush at count 5 with push and pop in the same cycle
    n = 0;
    while (count != 5 && n < 20) begin
      step(1'b1, 32'h3000 + 32'(n * 4), 1'b0, 1'b0);
      n++;
    end
    check("flush_reach5", WIDTH'(count), WIDTH'(5));
    br_e     = 1'b1;
    sb_ready = 1'b1;
    step(1'b0, 32'h0, 1'b0, 1'b0);
    check("flush_count", WIDTH'(count), '0);
    check("flush_valid", WIDTH'(sb_valid), '0);
    check("flush_stall", WIDTH'(stall), '0);
    step(1'b1, 32'h4000_0040, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    check("flush_after_pc", WIDTH'(bus_pc(sb_bus)), WIDTH'(32'h4000_0040));
    step(1'b0, 32'h0, 1'b1, 1'b0);

    // Stream 20 words across pointer wrap
    for (int i = 0; i < 20; i++) step(1'b1, 32'h100 + 32'(i * 4), 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) == 0,
           $urandom_range(0, 40) == 0);
    end
    for (int i = 0; i < 12; i++) step(1'b0, 32'h0, 1'b1, 1'b0);

    // Async reset between edges with count 4
    n = 0;
    while (count != 4 && n < 20) begin
      step(1'b1, 32'h5000 + 32'(n * 4), 1'b0, 1'b0);
      n++;
    end
    check("areset_reach4", WIDTH'(count), WIDTH'(4));
    mon_en = 1'b0;
    #2;
    resetn = 1'b0;
    #1;
    check("areset_count", WIDTH'(count), '0);
    check("areset_valid", WIDTH'(sb_valid), '0);
    check("areset_stall", WIDTH'(stall), '0);
    exp_q.delete();
    fresh      = 1'b0;
    inst_valid = 1'b0;
    sb_ready   = 1'b0;
    br_e       = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    for (int i = 0; i < 10; i++) step(1'b1, 32'h6000 + 32'(i * 4), 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1, 1'b0);

    @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/inst_queue.md
Name: inst_queue

Overview:
- Decoupling FIFO between the decode stage and the scoreboard.
- Captures each freshly decoded id_to_sb_bus word and presents entries to the scoreboard in program order with a valid/ready handshake.
- Generates the decoder stall so no decoded instruction is lost or duplicated.
- Flushes all contents on a branch redirect (br_e).

Parameters:
- DEPTH, 8, number of entries; power of two, minimum 4.
- WIDTH, `ID_TO_SB_WD (137), payload width of one decoded instruction.
- PTR_W, $clog2(DEPTH), width of the read and write pointers.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- resetn  input  1  reset, asynchronous, active-low.
- br_e  input  1  branch redirect; flushes the queue.
- inst_valid  input  1  decoder output word is a legal instruction.
- id_to_sb_bus  input  WIDTH  decoded instruction payload.
- stall  output  1  to decoder; holds decode and fetch.
- sb_valid  output  1  head entry is valid.
- sb_bus  output  WIDTH  head entry payload.
- sb_ready  input  1  scoreboard accepts the head this cycle.
- count  output  PTR_W+1  current occupancy, 0..DEPTH.

Behaviour:
- Async reset (resetn=0):
  - rd_ptr=0, wr_ptr=0, count=0, stall_q=0.
  - Outputs: sb_valid=0, stall=0, sb_bus=0 (storage array itself is not reset; sb_bus is masked to 0 when empty).
- stall = (count >= DEPTH-1). Combinational from registered count only; no dependence on sb_ready or inputs.
- stall_q: a register that samples stall every clock. It is cleared on flush.
- Freshness rule. The decoder holds its registered instruction unchanged while stalled, so one word can be visible across several cycles. It presents a newly loaded word only in the cycle after a clock edge at which stall was low.
  - push = inst_valid & ~stall_q & ~br_e.
  - Consequences:
    - The word present in the cycle stall first rises is pushed.
    - Held words are never re-pushed.
    - The word the decoder reloads from its skid buffer (the first cycle after stall falls) is pushed.
- Capacity proof obligation: push only occurs when count at the prior edge was < DEPTH-1. Occupancy therefore never exceeds DEPTH. Assert (sim only) that push never occurs with count==DEPTH.
- pop = sb_valid & sb_ready & ~br_e.
- sb_valid = (count != 0). sb_bus = mem[rd_ptr].
- Latency: a word pushed in cycle t is visible at the head in cycle t+1 at the earliest. There is no same-cycle bypass.
- Per-edge update, priority highest first:
  1. br_e=1: rd_ptr=wr_ptr=0, count=0, stall_q=0. Any push or pop in this cycle is discarded.
  2. Otherwise:
     - push: mem[wr_ptr] <= id_to_sb_bus, wr_ptr+1 mod DEPTH.
     - pop: rd_ptr+1 mod DEPTH.
     - count += push - pop.
- Simultaneous push and pop:
  - When count==0, pop is impossible, since sb_valid=0.
  - When count==DEPTH, push is impossible by construction.
  - At every other count, both occur and count is unchanged.
- Pointer wrap-around: natural PTR_W-bit overflow. count distinguishes full from empty.
- sb_ready with sb_valid=0 is ignored.
- inst_valid=0 words (bubbles, the decoder's zeroed pc after a branch) are never stored.
- Reset mid-operation: all state is discarded immediately and asynchronously; no partial update on the edge where reset is released.

Decomposition:
- Width constants:
  - `ID_TO_SB_WD and the bus field offsets stay in lib/defines.vh.
  - Add `IQ_DEPTH there as the system default.
- Sub-module fifo_ram: DEPTH x WIDTH storage with one synchronous write port and one asynchronous read port, no reset.
- Pointer, count and control logic lives in inst_queue.

Test Plan:
- Reset and single pass: push one word (pc field 0xBFC00000) with sb_ready=0. Required: sb_valid=1 and sb_bus equal to that word in the next cycle. Then sb_ready=1 gives sb_valid=0 one cycle later and count=0.
- Fill and stall: push every cycle with sb_ready=0 and DEPTH=8.
  - stall rises when count reaches 7, with the push in that cycle still accepted, so count ends at 8.
  - Holding inst_valid=1 for 5 more cycles leaves count=8 with no overflow and no duplicate entries.
- Release with skid: from full, pulse sb_ready for 2 cycles.
  - Required: stall falls when count=6.
  - The decoder's buffered word is pushed exactly once; the scoreboard later sees it exactly once, in order.
- Flush: with count=5, assert br_e in the same cycle as push=1 and pop=1.
  - Required next cycle: count=0, sb_valid=0, stall=0.
  - A following push is seen at the head with pc intact.
- Wrap-around: stream 20 words with sb_ready=1 (throughput 1 per cycle after the first). Output order must match input order (pc 0x100..0x14C step 4) across pointer wrap.
- Async reset: drop resetn between clock edges while count=4. Required: count=0, sb_valid=0, stall=0 immediately, before the next edge.
